// File: rtl/fault_diag_writer.sv
// fault_diag_writer: accumulates per-PE mismatch results into an N x N fault map and streams it row by row to eNVM.
module fault_diag_writer #(
  parameter int SYSTOLIC_SIZE    = 8,
  parameter int ADDR_WIDTH       = $clog2(SYSTOLIC_SIZE),
  parameter int ROW_FAULT_THRESH = 2,
  parameter int COL_FAULT_THRESH = 2
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           clear,
  input  logic                                           mismatch_valid,
  input  logic [ADDR_WIDTH-1:0]                          mismatch_row,
  input  logic [SYSTOLIC_SIZE-1:0]                       mismatch_pe,
  input  logic                                           commit,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           detection_en,
  output logic [ADDR_WIDTH-1:0]                          detection_addr,
  output logic [SYSTOLIC_SIZE-1:0]                       single_pe_detection,
  output logic                                           row_fault_detection,
  output logic                                           column_fault_detection,
  output logic [$clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1)-1:0] fault_count
);
  localparam int N  = SYSTOLIC_SIZE;
  localparam int CW = $clog2(N*N+1);
  typedef enum logic [1:0] {IDLE, CLASSIFY, WRITE, DONE} state_t;
  state_t                 state;
  logic [N-1:0][N-1:0]    map, map_t;
  logic [N-1:0]           row_flags, col_flags, row_nxt, col_nxt;
  logic [CW-1:0]          total;
  always_comb begin
    map_t   = '0;
    row_nxt = '0;
    col_nxt = '0;
    total   = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        map_t[c][r] = map[r][c];
    for (int i = 0; i < N; i++) begin
      row_nxt[i] = $countones(map[i]) >= ROW_FAULT_THRESH;
      col_nxt[i] = $countones(map_t[i]) >= COL_FAULT_THRESH;
      total      = total + CW'($countones(map[i]));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      map            <= '0;
      row_flags      <= '0;
      col_flags      <= '0;
      fault_count    <= '0;
      detection_addr <= '0;
      detection_en   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            map         <= '0;
            fault_count <= '0;
          end else begin
            if (mismatch_valid) map[mismatch_row] <= map[mismatch_row] | mismatch_pe;
            if (commit) begin
              state <= CLASSIFY;
              busy  <= 1'b1;
            end
          end
        end
        CLASSIFY: begin
          row_flags      <= row_nxt;
          col_flags      <= col_nxt;
          fault_count    <= total;
          detection_addr <= '0;
          detection_en   <= 1'b1;
          state          <= WRITE;
        end
        WRITE: begin
          if (detection_addr == ADDR_WIDTH'(N-1)) begin
            state          <= DONE;
            detection_en   <= 1'b0;
            detection_addr <= '0;
            busy           <= 1'b0;
            done           <= 1'b1;
          end else detection_addr <= detection_addr + 1'b1;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
  assign single_pe_detection    = detection_en ? map[detection_addr] : '0;
  assign row_fault_detection    = detection_en & row_flags[detection_addr];
  assign column_fault_detection = detection_en & col_flags[detection_addr];
endmodule

// File: tb/tb_fault_diag_writer.sv
// tb_fault_diag_writer: directed scenario tests of the fault map write-back with hand-computed expectations.
module tb_fault_diag_writer;
  localparam int N = 8;
  logic       clk = 0, rst_n = 0, clear = 0, mismatch_valid = 0, commit = 0;
  logic [2:0] mismatch_row = 0;
  logic [7:0] mismatch_pe = 0;
  logic       busy, done, detection_en, row_fault_detection, column_fault_detection;
  logic [2:0] detection_addr;
  logic [7:0] single_pe_detection;
  logic [6:0] fault_count;
  int total = 0, bad = 0;
  logic [7:0] cap_pe [N];
  logic       cap_row [N], cap_col [N];
  int strobes, done_at, order_err, busy_err;

  fault_diag_writer dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mismatch_valid(mismatch_valid),
    .mismatch_row(mismatch_row), .mismatch_pe(mismatch_pe), .commit(commit),
    .busy(busy), .done(done), .detection_en(detection_en), .detection_addr(detection_addr),
    .single_pe_detection(single_pe_detection), .row_fault_detection(row_fault_detection),
    .column_fault_detection(column_fault_detection), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  task automatic pulse_clear();
    @(negedge clk); clear = 1;
    @(negedge clk); clear = 0;
  endtask

  task automatic send(input logic [2:0] r, input logic [7:0] p);
    @(negedge clk); mismatch_valid = 1; mismatch_row = r; mismatch_pe = p;
    @(negedge clk); mismatch_valid = 0; mismatch_pe = 0; mismatch_row = 0;
  endtask

  // Commit then record every strobe; noise drives clear/commit/mismatch while the writer is busy.
  task automatic do_commit(input bit noise);
    for (int i = 0; i < N; i++) begin cap_pe[i] = 8'hEE; cap_row[i] = 1'bx; cap_col[i] = 1'bx; end
    strobes = 0; done_at = -1; order_err = 0; busy_err = 0;
    @(negedge clk); commit = 1;
    @(negedge clk); commit = 0;
    for (int j = 0; j < 30 && done_at < 0; j++) begin
      if (detection_en) begin
        if (strobes < N) begin
          cap_pe[strobes] = single_pe_detection;
          cap_row[strobes] = row_fault_detection;
          cap_col[strobes] = column_fault_detection;
          if (detection_addr != 3'(strobes)) order_err++;
        end
        strobes++;
      end
      if ((j <= N) != busy) busy_err++;
      if (done) done_at = j;
      if (noise && j < N) begin
        mismatch_valid = 1; mismatch_row = 7; mismatch_pe = 8'hFF; commit = 1; clear = 1;
      end else begin
        mismatch_valid = 0; mismatch_row = 0; mismatch_pe = 0; commit = 0; clear = 0;
      end
      if (done_at < 0) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic check_stream(input string name, input logic [7:0] pe [N], input logic [7:0] rf,
                              input logic [7:0] cf, input logic [6:0] fc);
    total++; if (strobes !== N) begin bad++; $display("FAIL %s strobes got=%0d want=%0d", name, strobes, N); end
    total++; if (done_at !== N+1) begin bad++; $display("FAIL %s done_latency got=%0d want=%0d", name, done_at, N+1); end
    total++; if (order_err !== 0) begin bad++; $display("FAIL %s addr_order errors=%0d want=0", name, order_err); end
    total++; if (busy_err !== 0) begin bad++; $display("FAIL %s busy_window errors=%0d want=0", name, busy_err); end
    total++; if (fault_count !== fc) begin bad++; $display("FAIL %s fault_count got=%0d want=%0d", name, fault_count, fc); end
    for (int i = 0; i < N; i++) begin
      total++; if (cap_pe[i] !== pe[i]) begin bad++; $display("FAIL %s pe[%0d] got=%h want=%h", name, i, cap_pe[i], pe[i]); end
      total++; if (cap_row[i] !== rf[i]) begin bad++; $display("FAIL %s row_flag[%0d] got=%b want=%b", name, i, cap_row[i], rf[i]); end
      total++; if (cap_col[i] !== cf[i]) begin bad++; $display("FAIL %s col_flag[%0d] got=%b want=%b", name, i, cap_col[i], cf[i]); end
    end
  endtask

  task automatic test_reset();
    logic [7:0] z [N];
    for (int i = 0; i < N; i++) z[i] = 0;
    repeat (2) @(negedge clk);
    total++; if ({busy, done, detection_en, detection_addr, single_pe_detection, row_fault_detection,
                  column_fault_detection, fault_count} !== '0) begin
      bad++; $display("FAIL reset_outputs busy=%b done=%b en=%b addr=%0d pe=%h fc=%0d want all 0",
                      busy, done, detection_en, detection_addr, single_pe_detection, fault_count);
    end
    rst_n = 1;
    do_commit(0);
    check_stream("reset_map", z, 8'h00, 8'h00, 7'd0);
  endtask

  task automatic test_single_fault();
    logic [7:0] e [N];
    for (int i = 0; i < N; i++) e[i] = (i == 3) ? 8'h04 : 8'h00;
    pulse_clear();
    send(3, 8'h04);
    do_commit(0);
    check_stream("single", e, 8'h00, 8'h00, 7'd1);
  endtask

  task automatic test_row_fault();
    logic [7:0] e [N];
    for (int i = 0; i < N; i++) e[i] = (i == 5) ? 8'h81 : 8'h00;
    pulse_clear();
    send(5, 8'h81);
    send(5, 8'h81);
    do_commit(0);
    check_stream("row", e, 8'h20, 8'h00, 7'd2);
    do_commit(0);
    check_stream("row_retained", e, 8'h20, 8'h00, 7'd2);
  endtask

  task automatic test_column_fault();
    logic [7:0] e [N];
    for (int i = 0; i < N; i++) e[i] = (i == 1 || i == 6) ? 8'h10 : 8'h00;
    pulse_clear();
    send(1, 8'h10);
    send(6, 8'h10);
    do_commit(0);
    check_stream("column", e, 8'h00, 8'h10, 7'd2);
  endtask

  task automatic test_priority();
    logic [7:0] z [N], e [N];
    int extra;
    for (int i = 0; i < N; i++) begin z[i] = 0; e[i] = (i == 0) ? 8'h01 : 8'h00; end
    pulse_clear();
    send(4, 8'h02);
    @(negedge clk); clear = 1; mismatch_valid = 1; mismatch_row = 2; mismatch_pe = 8'hFF; commit = 1;
    @(negedge clk); clear = 0; mismatch_valid = 0; mismatch_pe = 0; commit = 0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL prio_commit_dropped busy got=%b want=0", busy); end
    do_commit(0);
    check_stream("prio_clear", z, 8'h00, 8'h00, 7'd0);
    send(0, 8'h01);
    do_commit(1);
    check_stream("prio_busy", e, 8'h00, 8'h00, 7'd1);
    extra = 0;
    repeat (12) begin @(negedge clk); if (detection_en || busy) extra++; end
    total++; if (extra !== 0) begin bad++; $display("FAIL prio_second_writeback cycles got=%0d want=0", extra); end
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] z [N];
    int dones;
    bit found;
    for (int i = 0; i < N; i++) z[i] = 0;
    pulse_clear();
    send(2, 8'h0F);
    @(negedge clk); commit = 1;
    @(negedge clk); commit = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (detection_en && detection_addr == 3'd4) found = 1; else @(negedge clk);
    end
    total++; if (!found) begin bad++; $display("FAIL midreset_reach_addr4 got=0 want=1"); end
    rst_n = 0;
    #1;
    total++; if ({detection_en, busy, done, detection_addr, single_pe_detection} !== '0) begin
      bad++; $display("FAIL midreset_outputs en=%b busy=%b done=%b addr=%0d pe=%h want all 0",
                      detection_en, busy, done, detection_addr, single_pe_detection);
    end
    @(negedge clk); rst_n = 1;
    dones = 0;
    repeat (12) begin @(negedge clk); if (done || detection_en) dones++; end
    total++; if (dones !== 0) begin bad++; $display("FAIL midreset_no_done cycles got=%0d want=0", dones); end
    do_commit(0);
    check_stream("midreset_map", z, 8'h00, 8'h00, 7'd0);
  endtask

  initial begin
    test_reset();
    test_single_fault();
    test_row_fault();
    test_column_fault();
    test_priority();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fault_diag_writer.md
FAULT_DIAG_WRITER -- requirements
Module: fault_diag_writer

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 8, the array dimension (N).
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(SYSTOLIC_SIZE), the row/column index width.
REQ-003 SHALL have parameter ROW_FAULT_THRESH, default 2, the minimum faulty PEs in one row that flags a row fault.
REQ-004 SHALL have parameter COL_FAULT_THRESH, default 2, the minimum faulty PEs in one column that flags a column fault.
REQ-005 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  zero the fault map (new diagnosis session)
- mismatch_valid  in  1  mismatch_row/mismatch_pe carry one compare result
- mismatch_row  in  ADDR_WIDTH  PE row of the compare result
- mismatch_pe  in  N  per-column mismatch bits for that row; bit j = column j
- commit  in  1  request write-back of the map to eNVM
- busy  out  1  write-back in progress
- done  out  1  one-cycle pulse when write-back completes
- detection_en  out  1  eNVM store strobe
- detection_addr  out  ADDR_WIDTH  eNVM row/column index being stored
- single_pe_detection  out  N  fault map row detection_addr
- row_fault_detection  out  1  row detection_addr is a faulty row
- column_fault_detection  out  1  column detection_addr is a faulty column
- fault_count  out  $clog2(N*N+1)  total faulty PEs in the map at the last commit

Function
REQ-006 SHALL hold an N x N fault map register, map[r][c].
REQ-007 SHALL implement the FSM IDLE -> CLASSIFY -> WRITE -> DONE -> IDLE.
REQ-008 SHALL, in IDLE on mismatch_valid, set map[mismatch_row] |= mismatch_pe (OR-accumulate; a repeated fault is counted once).
REQ-009 SHALL, in IDLE on clear, zero the map and fault_count; clear SHALL win over mismatch_valid and commit in the same cycle (both dropped).
REQ-010 SHALL, in IDLE on commit without clear, go to CLASSIFY; a same-cycle mismatch_valid SHALL be accumulated before classification.
REQ-011 SHALL spend exactly one cycle in CLASSIFY, registering per-row flags (popcount(map[r]) >= ROW_FAULT_THRESH), per-column flags (popcount over r of map[r][c] >= COL_FAULT_THRESH) and fault_count (popcount of the whole map).
REQ-012 SHALL spend exactly N cycles in WRITE with detection_en=1, detection_addr = 0,1,...,N-1 in order, single_pe_detection = map[addr], row_fault_detection = row flag[addr], column_fault_detection = column flag[addr].
REQ-013 SHALL assert busy in CLASSIFY and WRITE only.
REQ-014 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-015 SHALL, outside IDLE, ignore mismatch_valid, clear and commit.
REQ-016 SHALL drive detection_en, detection_addr, single_pe_detection, row_fault_detection and column_fault_detection to 0 outside WRITE.
REQ-017 SHALL retain the map after DONE, so a later commit re-stores the accumulated result.
REQ-018 SHALL complete commit-to-done in N+2 cycles: commit sampled at edge k, first store at edge k+2, done high in the cycle after edge k+N+1.

Reset
REQ-019 SHALL, on rst_n low at any time (including mid-WRITE), immediately force state IDLE, map zero, flags zero, fault_count 0 and all outputs 0, with no done pulse.
REQ-020 SHALL, after rst_n rises, accept inputs on the first posedge.

Verification
REQ-021 Reset: rst_n low -> all outputs 0; map zero (a following commit stores all-zero rows, fault_count=0).
REQ-022 Single fault: clear; mismatch row 3 pe=0x04; commit -> 8 strobes, addr 3 single_pe=0x04, all other rows 0x00, all row/column flags 0, fault_count=1, done N+2 cycles after commit.
REQ-023 Row fault: row 5 pe=0x81, sent twice -> addr 5 row_fault=1, columns 0 and 7 column_fault=0, fault_count=2.
REQ-024 Column fault: row 1 pe=0x10 and row 6 pe=0x10 -> column_fault=1 at addr 4 only, row flags all 0, fault_count=2.
REQ-025 Priority: clear together with mismatch row 2 pe=0xFF -> map zero; a mismatch or commit while busy=1 -> stored data unchanged and no second write-back.
REQ-026 Reset mid-operation: rst_n low while addr=4 in WRITE -> detection_en=0 immediately, no done pulse, a later commit stores all zeros.
